pwm_capture: RTL and testbench

PWM measurement block, the receive side of the RGB LED PWM generators. It samples an external or looped-back PWM waveform and measures high time and period in system-clock cycles. It converts the ratio into a DUTY_W-bit duty code on the same scale the LED pwm generators consume. Used for self-test of the LED PWM path and for reading externally driven PWM inputs.

---
 rtl/pwm_capture_pkg.sv | 18 +
 rtl/pwm_div.sv | 85 ++++++++
 rtl/pwm_capture.sv | 179 +++++++++++++++++
 tb/tb_pwm_capture.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared state encoding and duty scale for the PWM capture/generator pair
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_t;

  localparam int PWM_DUTY_W = 4;

  function automatic int duty_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int DUTY_MAX = duty_max(PWM_DUTY_W);

endpackage

// File: rtl/pwm_div.sv
// rtl/pwm_div.sv - restoring divider producing floor(num * 2^DUTY_W / den), one bit per cycle
module pwm_div #(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_num,
  input  logic [CNT_W-1:0]  i_den,
  output logic              o_busy,
  output logic              o_done,
  output logic [DUTY_W-1:0] o_q
);

  localparam int QW = $clog2(DUTY_W + 1);

  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_den;
  logic [DUTY_W-1:0] r_q;
  logic [QW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_sat;

  logic [CNT_W-1:0]  w_rem_in;
  logic [CNT_W-1:0]  w_den;
  logic [CNT_W:0]    w_shift;
  logic              w_ge;
  logic [CNT_W-1:0]  w_rem_nx;

  // The start cycle already resolves the MSB, so the quotient is ready after DUTY_W edges.
  always_comb begin
    w_rem_in = r_rem;
    w_den    = r_den;
    if (i_start) begin
      w_den    = i_den;
      w_rem_in = (i_num >= i_den) ? '0 : i_num;
    end
    w_shift  = {w_rem_in, 1'b0};
    w_ge     = (w_shift >= {1'b0, w_den});
    w_rem_nx = w_ge ? (w_shift[CNT_W-1:0] - w_den) : w_shift[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sat  <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_den  <= i_den;
        r_sat  <= (i_num >= i_den);
        r_rem  <= w_rem_nx;
        r_q    <= DUTY_W'(w_ge);
        r_cnt  <= QW'(DUTY_W - 1);
        r_busy <= (DUTY_W > 1);
        r_done <= (DUTY_W == 1);
      end else if (r_busy) begin
        r_rem <= w_rem_nx;
        r_q   <= (r_q << 1) | DUTY_W'(w_ge);
        r_cnt <= r_cnt - QW'(1);
        if (r_cnt == QW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  // Busy covers the hand-off cycle too, so a new period cannot clobber an unread quotient.
  assign o_busy = r_busy | r_done;
  assign o_done = r_done;
  assign o_q    = r_sat ? '1 : r_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures PWM high time and period, converts them to a duty code
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DUTY_W      = PWM_DUTY_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic              valid,
  output logic              timeout,
  output logic              overrun
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [DUTY_W-1:0] DUTY_ONES = DUTY_W'(duty_max(DUTY_W));

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s, w_rise, w_fall;

  pwm_state_t       r_state, w_state_n;
  logic [CNT_W-1:0] r_hc, r_pc, r_h_lat, r_h_pend, r_p_pend;
  logic             w_tmo, w_close, w_restart, w_latch, w_stuck_hi, w_stuck_lo;

  logic              w_div_busy, w_div_done, w_div_start;
  logic [DUTY_W-1:0] w_div_q;

  logic [DUTY_W-1:0] r_duty;
  logic [CNT_W-1:0]  r_high, r_period;
  logic              r_valid, r_timeout, r_overrun;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d  <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  assign w_tmo  = (r_pc == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_n;
  end

  // A rise in LOW closes the period even when the counter has just hit its limit.
  always_comb begin
    w_state_n  = r_state;
    w_close    = 1'b0;
    w_restart  = 1'b0;
    w_latch    = 1'b0;
    w_stuck_hi = 1'b0;
    w_stuck_lo = 1'b0;
    if (!enable) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_rise) begin
          w_state_n = ST_HIGH;
          w_restart = 1'b1;
        end
        ST_HIGH: if (w_tmo) begin
          w_stuck_hi = 1'b1;
          w_state_n  = ST_IDLE;
        end else if (w_fall) begin
          w_latch   = 1'b1;
          w_state_n = ST_LOW;
        end
        ST_LOW: if (w_rise) begin
          w_close   = 1'b1;
          w_restart = 1'b1;
          w_state_n = ST_HIGH;
        end else if (w_tmo) begin
          w_stuck_lo = 1'b1;
          w_state_n  = ST_IDLE;
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hc    <= '0;
      r_pc    <= '0;
      r_h_lat <= '0;
    end else begin
      if (w_state_n == ST_IDLE) begin
        r_hc <= '0;
        r_pc <= '0;
      end else if (w_restart) begin
        r_hc <= CNT_W'(1);
        r_pc <= CNT_W'(1);
      end else begin
        r_pc <= r_pc + CNT_W'(1);
        if (r_state == ST_HIGH) r_hc <= r_hc + CNT_W'(1);
      end
      if (w_latch) r_h_lat <= r_hc;
    end
  end

  assign w_div_start = w_close & ~w_div_busy;

  pwm_div #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_div_start),
    .i_abort (~enable),
    .i_num   (r_h_lat),
    .i_den   (r_pc),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .o_q     (w_div_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_duty    <= '0;
      r_high    <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
      r_h_pend  <= '0;
      r_p_pend  <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      if (!enable)                    r_overrun <= 1'b0;
      else if (w_close && w_div_busy) r_overrun <= 1'b1;
      if (w_div_start) begin
        r_h_pend <= r_h_lat;
        r_p_pend <= r_pc;
      end
      if (w_stuck_hi) begin
        r_valid   <= 1'b1;
        r_timeout <= 1'b1;
        r_duty    <= DUTY_ONES;
        r_high    <= CNT_MAX;
        r_period  <= CNT_MAX;
      end else if (w_stuck_lo) begin
        r_valid   <= 1'b1;
        r_timeout <= 1'b1;
        r_duty    <= '0;
        r_high    <= '0;
        r_period  <= CNT_MAX;
      end else if (w_div_done && enable) begin
        r_valid  <= 1'b1;
        r_duty   <= w_div_q;
        r_high   <= r_h_pend;
        r_period <= r_p_pend;
      end
    end
  end

  assign duty       = r_duty;
  assign high_cnt   = r_high;
  assign period_cnt = r_period;
  assign valid      = r_valid;
  assign timeout    = r_timeout;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture against an event-level model
module tb_pwm_capture;

  localparam int CW   = 8;
  localparam int DW   = 4;
  localparam int SS   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          pwm_in = 1'b0;
  logic [DW-1:0] duty;
  logic [CW-1:0] high_cnt, period_cnt;
  logic          valid, timeout, overrun;

  pwm_capture #(.CNT_W(CW), .DUTY_W(DW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int nvalid = 0;
  logic last_tmo = 1'b0;

  typedef struct {
    int reg_p;
    int high;
    int period;
    int duty;
    int tmo;
  } res_t;

  res_t pend[$];
  bit   hist[SS+1];
  int   cyc, start_p, fall_p, last_acc;
  bit   meas;
  int   e_valid, e_timeout, e_overrun, e_duty, e_high, e_period;

  function automatic void model_reset();
    for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
    meas = 1'b0; pend.delete(); last_acc = -1000;
    e_valid = 0; e_timeout = 0; e_overrun = 0; e_duty = 0; e_high = 0; e_period = 0;
  endfunction

  // Model: the input is seen SS+1 edges late; a result appears DW edges after its closing edge.
  function automatic void model_step(input bit pin, input bit en);
    bit rise, fall;
    int age, h, d;
    res_t r;
    rise = hist[SS-1] && !hist[SS];
    fall = !hist[SS-1] && hist[SS];
    for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pin;
    e_valid = 0;
    e_timeout = 0;
    if (!en) begin
      meas = 1'b0; pend.delete(); last_acc = -1000; e_overrun = 0;
    end else if (meas) begin
      age = cyc - start_p;
      if (rise) begin
        if (cyc - last_acc >= DW + 1) begin
          h = fall_p - start_p;
          d = (h << DW) / age;
          if (d > DMAX) d = DMAX;
          pend.push_back('{cyc + DW, h, age, d, 0});
          last_acc = cyc;
        end else begin
          e_overrun = 1;
        end
        start_p = cyc;
        fall_p = -1;
      end else if (age == CMAX) begin
        if (fall_p < 0) pend.push_back('{cyc, CMAX, CMAX, DMAX, 1});
        else            pend.push_back('{cyc, 0, CMAX, 0, 1});
        meas = 1'b0;
      end else if (fall && fall_p < 0) begin
        fall_p = cyc;
      end
    end else if (rise) begin
      meas = 1'b1; start_p = cyc; fall_p = -1;
    end
    if (pend.size() > 0 && pend[0].reg_p == cyc) begin
      r = pend.pop_front();
      e_valid = 1; e_timeout = r.tmo; e_duty = r.duty; e_high = r.high; e_period = r.period;
    end
  endfunction

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin
        cyc++;
        model_step(pwm_in, enable);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if (valid !== 1'(e_valid) || timeout !== 1'(e_timeout) || overrun !== 1'(e_overrun) ||
          duty !== DW'(e_duty) || high_cnt !== CW'(e_high) || period_cnt !== CW'(e_period)) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t: got v=%b t=%b o=%b d=%0d h=%0d p=%0d, expected v=%0d t=%0d o=%0d d=%0d h=%0d p=%0d",
                 $time, valid, timeout, overrun, duty, high_cnt, period_cnt,
                 e_valid, e_timeout, e_overrun, e_duty, e_high, e_period);
      end
      if (valid === 1'b1) begin
        nvalid++;
        last_tmo = timeout;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pwm(input int hi, input int lo, input int reps);
    repeat (reps) begin
      pwm_in = 1'b1;
      repeat (hi) tick();
      pwm_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  initial begin
    int nv, hi, lo;
    #1 rst = 1'b0;
    repeat (3) tick();
    chk("reset_valid", int'(valid), 0);
    chk("reset_duty", int'(duty), 0);
    chk("reset_period", int'(period_cnt), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst = 1'b1;
    enable = 1'b1;
    repeat (4) tick();

    nv = nvalid;
    pwm(5, 11, 1);
    chk("no_valid_before_second_rise", nvalid - nv, 0);
    pwm(5, 11, 2);
    chk("p5_11_valids", nvalid - nv, 2);
    chk("p5_11_high", int'(high_cnt), 5);
    chk("p5_11_period", int'(period_cnt), 16);
    chk("p5_11_duty", int'(duty), 5);
    chk("p5_11_timeout", int'(last_tmo), 0);

    pwm(3, 13, 3);
    chk("p3_13_duty", int'(duty), 3);
    pwm(15, 1, 3);
    chk("p15_1_duty", int'(duty), 15);
    chk("p15_1_high", int'(high_cnt), 15);

    pwm(2, 2, 6);
    chk("overrun_set", int'(overrun), 1);
    pwm(2, 2, 2);
    chk("overrun_sticky", int'(overrun), 1);
    enable = 1'b0;
    repeat (2) tick();
    chk("overrun_cleared", int'(overrun), 0);
    enable = 1'b1;

    pwm(5, 11, 2);
    nv = nvalid;
    pwm_in = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    repeat (8) tick();
    chk("abort_no_valid", nvalid - nv, 0);
    chk("abort_duty_held", int'(duty), 5);
    enable = 1'b1;

    pwm_in = 1'b0;
    repeat (5) tick();
    pwm_in = 1'b1;
    repeat (300) tick();
    chk("stuck_hi_timeout", int'(last_tmo), 1);
    chk("stuck_hi_duty", int'(duty), 15);
    chk("stuck_hi_high", int'(high_cnt), 255);
    chk("stuck_hi_period", int'(period_cnt), 255);

    pwm_in = 1'b0;
    repeat (5) tick();
    pwm_in = 1'b1;
    repeat (10) tick();
    pwm_in = 1'b0;
    repeat (300) tick();
    chk("stuck_lo_timeout", int'(last_tmo), 1);
    chk("stuck_lo_duty", int'(duty), 0);
    chk("stuck_lo_high", int'(high_cnt), 0);
    chk("stuck_lo_period", int'(period_cnt), 255);

    repeat (40) begin
      hi = $urandom_range(1, 40);
      lo = $urandom_range(1, 40);
      pwm(hi, lo, 1);
      if ($urandom_range(0, 7) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        enable = 1'b1;
      end
    end

    pwm_in = 1'b0;
    repeat (5) tick();
    pwm_in = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_high", int'(high_cnt), 0);
    chk("midrst_period", int'(period_cnt), 0);
    tick();
    rst = 1'b1;
    nv = nvalid;
    repeat (3) tick();
    pwm_in = 1'b0;
    repeat (8) tick();
    chk("post_rst_no_valid", nvalid - nv, 0);
    pwm(4, 12, 2);
    chk("post_rst_duty", int'(duty), 4);
    chk("post_rst_period", int'(period_cnt), 16);

    repeat (20) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
